univ_shift_seq: RTL and testbench
=================================

UNIV_SHIFT_SEQ -- requirements
Module: univ_shift_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width; legal range 2..64.
REQ-002 SHALL have localparam CNT_W, value $clog2(WIDTH+1), shift-count width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port iz  input  1  synchronous clear of po.
REQ-006 SHALL have port ld  input  1  parallel load of pi into po.
REQ-007 SHALL have port pi  input  WIDTH  parallel load data.
REQ-008 SHALL have port start  input  1  begin a multi-step shift.
REQ-009 SHALL have port cnt  input  CNT_W  number of single-bit steps.
REQ-010 SHALL have port dir  input  1  direction: 0 = left (toward MSB), 1 = right.
REQ-011 SHALL have port mode  input  2  step mode: 00 fill with sin, 01 rotate, 10 arithmetic right, 11 reserved.
REQ-012 SHALL have port sin  input  1  serial fill bit, sampled every shift step.
REQ-013 SHALL have port po  output  WIDTH  register contents.
REQ-014 SHALL have port sout  output  1  registered copy of the last bit shifted out.
REQ-015 SHALL have port busy  output  1  high in SHIFT state.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 In IDLE, priority SHALL be iz > ld > start: iz clears po; ld loads pi; start acts only when iz=ld=0.
REQ-019 start in IDLE with cnt!=0 SHALL latch min(cnt,WIDTH) into a remaining counter, latch dir and mode, and enter SHIFT; po is unchanged on that edge.
REQ-020 start in IDLE with cnt=0 SHALL go directly to DONE with po unchanged.
REQ-021 Each SHIFT cycle SHALL apply one step to po, update sout with the exiting bit, and decrement the counter; the step with counter=1 SHALL move the FSM to DONE.
REQ-022 Left step: po <= {po[W-2:0], fill}, exiting bit po[W-1]; right step: po <= {fill, po[W-1:1]}, exiting bit po[0].
REQ-023 Fill SHALL be sin (mode 00), the exiting bit (mode 01), po[W-1] for right or 0 for left (mode 10); mode 11 SHALL behave as 00.
REQ-024 Latency: with start sampled at edge k and N=min(cnt,WIDTH)>0, po SHALL be final at edge k+N, done SHALL be high for the cycle after edge k+N, and the FSM SHALL return to IDLE at edge k+N+1.
REQ-025 In SHIFT and DONE, ld, start, dir, mode and cnt SHALL be ignored.
REQ-026 iz in SHIFT SHALL abort: po <= 0, counter <= 0, next state IDLE, no done pulse.
REQ-027 iz in DONE SHALL clear po; done still pulses that cycle.
REQ-028 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); both are registered-state decodes with no input-to-output combinational path.

Reset
REQ-029 rst SHALL asynchronously force po=0, sout=0, counter=0, state IDLE, hence busy=0 and done=0.
REQ-030 rst asserted mid-shift SHALL discard the operation with no done pulse.

Configuration
REQ-031 With macro UNIV_SHIFT_SEQ_ARITH_EN defined, mode 10 SHALL behave per REQ-023; without it, mode 10 SHALL behave exactly as mode 00 and the sign-extension logic SHALL be absent.

Structure
REQ-032 Package univ_shift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and the mode enum with encodings 00/01/10/11.
REQ-033 The single-step combinational shifter SHALL be a sub-module usr_step_unit (inputs po, dir, mode, sin; outputs next po, exiting bit), instantiated once.

Verification (WIDTH=8)
REQ-034 ld=1 with pi=8'hA5, then start with cnt=3, dir=0, mode=00, sin=1 -> po=8'h2F after 3 cycles, sout=1, done high exactly one cycle, busy high 3 cycles.
REQ-035 po=8'h81, start with cnt=1, dir=1, mode=01 -> po=8'hC0, sout=1; start with cnt=0 -> po unchanged, done next cycle, busy never high.
REQ-036 po=8'h90, start with cnt=2, dir=1, mode=10 -> po=8'hE4 with UNIV_SHIFT_SEQ_ARITH_EN defined; with sin=0 and the macro undefined -> po=8'h24.
REQ-037 start with cnt=15 (saturates to 8), mode=00, sin=0, po=8'hFF -> po=8'h00 after 8 cycles; ld and start pulsed mid-shift have no effect.
REQ-038 iz asserted on the 2nd SHIFT cycle -> po=0, IDLE next cycle, no done; rst mid-shift -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift sequencer.
//   state_t : sequencer FSM states (IDLE / SHIFT / DONE)
//   mode_t  : per-step fill mode, encodings fixed at 00/01/10/11
package univ_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'b00,   // fill with serial input
        MODE_ROT   = 2'b01,   // rotate: exiting bit re-enters
        MODE_ARITH = 2'b10,   // arithmetic right (sign fill), zero fill left
        MODE_RSVD  = 2'b11    // treated as MODE_FILL
    } mode_t;

endpackage

// File: rtl/usr_step_unit.sv
// Single-step combinational shifter for univ_shift_seq.
// Ports:
//   po      in  current register contents
//   dir     in  0 = left (toward MSB), 1 = right
//   mode    in  fill mode (mode_t)
//   sin     in  serial fill bit
//   po_next out register contents after one step
//   bit_out out bit shifted out by this step
// Build option: UNIV_SHIFT_SEQ_ARITH_EN enables the sign-fill mode; without
// it MODE_ARITH falls through to serial fill and no sign logic exists.
module usr_step_unit
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] po,
    input  logic             dir,
    input  mode_t            mode,
    input  logic             sin,
    output logic [WIDTH-1:0] po_next,
    output logic             bit_out
);

    logic fill;

    always_comb begin
        bit_out = dir ? po[0] : po[WIDTH-1];
        fill    = sin;
        case (mode)
            MODE_ROT:   fill = bit_out;
`ifdef UNIV_SHIFT_SEQ_ARITH_EN
            MODE_ARITH: fill = dir ? po[WIDTH-1] : 1'b0;
`endif
            default:    fill = sin;
        endcase
        po_next = dir ? {fill, po[WIDTH-1:1]} : {po[WIDTH-2:0], fill};
    end

endmodule

// File: rtl/univ_shift_seq.sv
// Universal shift register with a multi-step shift sequencer.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   iz    in  synchronous clear of po (aborts a shift in progress)
//   ld    in  parallel load of pi (IDLE only)
//   pi    in  parallel load data
//   start in  begin a shift of min(cnt, WIDTH) single-bit steps
//   cnt   in  step count
//   dir   in  0 = left, 1 = right
//   mode  in  00 fill sin, 01 rotate, 10 arithmetic right, 11 as 00
//   sin   in  serial fill bit, sampled every step
//   po    out register contents
//   sout  out last bit shifted out (registered)
//   busy  out high while shifting
//   done  out one-cycle completion pulse
// Build option: UNIV_SHIFT_SEQ_ARITH_EN enables arithmetic mode 10
// (otherwise mode 10 behaves as mode 00).
//
// state | meaning
// IDLE  | waiting; iz > ld > start
// SHIFT | one step per cycle until the remaining count reaches zero
// DONE  | one-cycle completion pulse, then back to IDLE
module univ_shift_seq
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iz,
    input  logic             ld,
    input  logic [WIDTH-1:0] pi,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] po,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] remain;
    logic             dir_q;
    mode_t            mode_q;
    logic [CNT_W-1:0] cnt_sat;
    logic [WIDTH-1:0] step_po;
    logic             step_out;

    // Counts beyond WIDTH would only repeat work for fill modes; saturate.
    assign cnt_sat = (cnt > WIDTH_CNT) ? WIDTH_CNT : cnt;

    usr_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .po      (po),
        .dir     (dir_q),
        .mode    (mode_q),
        .sin     (sin),
        .po_next (step_po),
        .bit_out (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            po     <= '0;
            sout   <= 1'b0;
            remain <= '0;
            dir_q  <= 1'b0;
            mode_q <= MODE_FILL;
        end else begin
            case (state)
                IDLE: begin
                    if (iz) begin
                        po <= '0;
                    end else if (ld) begin
                        po <= pi;
                    end else if (start) begin
                        dir_q  <= dir;
                        mode_q <= mode_t'(mode);
                        if (cnt == '0) begin
                            state <= DONE;
                        end else begin
                            remain <= cnt_sat;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (iz) begin
                        po     <= '0;
                        remain <= '0;
                        state  <= IDLE;
                    end else begin
                        po     <= step_po;
                        sout   <= step_out;
                        remain <= remain - CNT_W'(1);
                        if (remain == CNT_W'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (iz)
                        po <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pure decodes of the state register: no input-to-output path.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_univ_shift_seq.sv
// Directed self-checking bench for univ_shift_seq at WIDTH=8.
module tb_univ_shift_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

`ifdef UNIV_SHIFT_SEQ_ARITH_EN
    localparam logic [7:0] ARITH_EXP = 8'hE4;
`else
    localparam logic [7:0] ARITH_EXP = 8'h24;
`endif

    logic             clk;
    logic             rst;
    logic             iz;
    logic             ld;
    logic [WIDTH-1:0] pi;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic [1:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] po;
    logic             sout;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;
    int n_busy;
    int n_done;

    univ_shift_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .iz    (iz),
        .ld    (ld),
        .pi    (pi),
        .start (start),
        .cnt   (cnt),
        .dir   (dir),
        .mode  (mode),
        .sin   (sin),
        .po    (po),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        ld = 1'b1;
        pi = v;
        tick();
        ld = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] c, input logic d, input logic [1:0] m, input logic s);
        start = 1'b1;
        cnt   = c;
        dir   = d;
        mode  = m;
        sin   = s;
        tick();
        start = 1'b0;
    endtask

    // Samples from the cycle after start; stops on the done cycle.
    task automatic run_shift(input int max_cyc, output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (busy) nb++;
            if (done) begin
                nd++;
                break;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; iz = 1'b0; ld = 1'b0; pi = '0; start = 1'b0;
        cnt = '0; dir = 1'b0; mode = 2'b00; sin = 1'b0;
        @(negedge clk);
        check("rst_po",   po,   8'h00);
        check("rst_sout", sout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        // Fill-left with sin=1: A5 -> 4B -> 97 -> 2F
        load(8'hA5);
        check("ld_po", po, 8'hA5);
        do_start(4'd3, 1'b0, 2'b00, 1'b1);
        check("start_po_hold", po, 8'hA5);
        run_shift(20, n_busy, n_done);
        check("fill_po",   po,     8'h2F);
        check("fill_sout", sout,   1'b1);
        check("fill_busy", n_busy, 3);
        check("fill_done", n_done, 1);
        tick();
        check("fill_done_1cyc", done, 1'b0);
        check("fill_idle",      busy, 1'b0);

        // Rotate right by one: 81 -> C0
        load(8'h81);
        do_start(4'd1, 1'b1, 2'b01, 1'b0);
        run_shift(20, n_busy, n_done);
        check("rot_po",   po,     8'hC0);
        check("rot_sout", sout,   1'b1);
        check("rot_busy", n_busy, 1);
        tick();

        // Zero count: straight to DONE, po untouched, never busy
        do_start(4'd0, 1'b0, 2'b00, 1'b1);
        run_shift(20, n_busy, n_done);
        check("cnt0_po",   po,     8'hC0);
        check("cnt0_busy", n_busy, 0);
        check("cnt0_done", n_done, 1);
        tick();
        check("cnt0_done_1cyc", done, 1'b0);

        // Arithmetic right by two on 90 (sin=0)
        load(8'h90);
        do_start(4'd2, 1'b1, 2'b10, 1'b0);
        run_shift(20, n_busy, n_done);
        check("arith_po",   po,   ARITH_EXP);
        check("arith_sout", sout, 1'b0);
        tick();

        // Saturated count 15 -> 8 steps; ld/start mid-shift ignored
        load(8'hFF);
        do_start(4'd15, 1'b0, 2'b00, 1'b0);
        check("sat_busy0", busy, 1'b1);
        ld = 1'b1; pi = 8'h5A; start = 1'b1; cnt = 4'd2; dir = 1'b1; mode = 2'b01;
        tick();
        ld = 1'b0; start = 1'b0;
        run_shift(40, n_busy, n_done);
        check("sat_po",   po,     8'h00);
        check("sat_sout", sout,   1'b1);
        check("sat_busy", n_busy, 7);
        check("sat_done", n_done, 1);
        tick();

        // iz has priority over ld in IDLE
        load(8'h3C);
        iz = 1'b1; ld = 1'b1; pi = 8'h33;
        tick();
        iz = 1'b0; ld = 1'b0;
        check("iz_over_ld", po, 8'h00);

        // iz on the 2nd SHIFT cycle aborts without done
        load(8'hA5);
        do_start(4'd5, 1'b0, 2'b00, 1'b1);
        tick();
        check("abort_step1", po, 8'h4B);
        iz = 1'b1;
        tick();
        iz = 1'b0;
        check("abort_po",   po,   8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        tick();
        check("abort_nodone", done, 1'b0);

        // iz during DONE clears po, done still pulses
        load(8'h77);
        do_start(4'd0, 1'b0, 2'b00, 1'b0);
        check("izdone_done", done, 1'b1);
        iz = 1'b1;
        tick();
        iz = 1'b0;
        check("izdone_po",   po,   8'h00);
        check("izdone_idle", done, 1'b0);

        // Async reset mid-shift: 5A left fill 1 -> B5 -> 6B (sout=1)
        load(8'h5A);
        do_start(4'd6, 1'b0, 2'b00, 1'b1);
        tick();
        tick();
        check("pre_rst_po",   po,   8'h6B);
        check("pre_rst_sout", sout, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_po",   po,   8'h00);
        check("arst_sout", sout, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("arst_nodone", done, 1'b0);
        check("arst_idle",   busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
